// File: rtl/fake_hss_pkg.sv
// fake_hss_pkg: shared types and defaults for the fake HSS lane model.
// Holds sequencer state encoding, counter width and parameter defaults.
package fake_hss_pkg;

  typedef enum logic [1:0] {
    ST_RST       = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_WAIT_RDY  = 2'd2,
    ST_READY     = 2'd3
  } hss_state_e;

  localparam int CNT_W = 10;

  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_DATAWIDTH = 40;
  localparam int DEF_LOCK_DLY  = 64;
  localparam int DEF_RDY_DLY   = 16;
  localparam int DEF_LB_LAT    = 2;

  // Reference clock usable and PLL powered.
  function automatic logic link_ok(
    input logic refclk_valid,
    input logic pdwn
  );
    return refclk_valid & ~pdwn;
  endfunction

  // Bits needed to hold a slip offset 0..dw-1.
  function automatic int off_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/fake_hss_lane.sv
// fake_hss_lane: one lane's loopback pipeline, valid gating and
// bit-slip rotator applied at the output.
module fake_hss_lane
  import fake_hss_pkg::*;
#(
  parameter int DW     = DEF_DATAWIDTH,
  parameter int LB_LAT = DEF_LB_LAT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ready_i,
  input  logic          flush_i,
  input  logic          en_i,
  input  logic          quiet_i,
  input  logic          slip_i,
  input  logic [DW-1:0] txd_i,
  output logic [DW-1:0] rxd_o,
  output logic          rxv_o
);

  localparam int OW = off_w(DW);

  logic [DW-1:0]     data_q [LB_LAT];
  logic [LB_LAT-1:0] vld_q;
  logic [OW-1:0]     off_q;
  logic [OW-1:0]     off_d;
  logic              v0;
  logic [DW-1:0]     d0;
  logic [DW-1:0]     last;
  logic [OW:0]       lsh;

  assign v0 = ready_i & en_i & ~quiet_i;
  assign d0 = v0 ? txd_i : '0;

  // Loopback shift register; leaving READY empties it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < LB_LAT; k++) data_q[k] <= '0;
      vld_q <= '0;
    end else if (flush_i) begin
      for (int k = 0; k < LB_LAT; k++) data_q[k] <= '0;
      vld_q <= '0;
    end else begin
      data_q[0] <= d0;
      vld_q[0]  <= v0;
      for (int k = 1; k < LB_LAT; k++) begin
        data_q[k] <= data_q[k-1];
        vld_q[k]  <= vld_q[k-1];
      end
    end
  end

  // Slip offset: advance on request in READY, wrap at DW-1.
  always_comb begin
    off_d = off_q;
    if (flush_i) begin
      off_d = '0;
    end else if (ready_i && slip_i) begin
      off_d = (off_q == OW'(DW - 1)) ? '0 : off_q + 1'b1;
    end
  end

  // Slip offset register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) off_q <= '0;
    else       off_q <= off_d;
  end

  // Rotate right by the offset: out bit j = data bit (j+off) mod DW.
  assign last  = data_q[LB_LAT-1];
  assign lsh   = (OW+1)'(DW) - {1'b0, off_q};
  assign rxd_o = (last >> off_q) | (last << lsh);
  assign rxv_o = vld_q[LB_LAT-1];

endmodule

// File: rtl/fake_hss_nlane.sv
// fake_hss_nlane: behavioural multi-lane HSS macro stand-in with a
// PLL lock/ready sequencer and per-lane TX-to-RX loopback.
module fake_hss_nlane
  import fake_hss_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int LOCK_DLY  = DEF_LOCK_DLY,
  parameter int RDY_DLY   = DEF_RDY_DLY,
  parameter int LB_LAT    = DEF_LB_LAT
) (
  input  logic                           HSSREFCLKAC,
  input  logic                           HSSRESET,
  input  logic                           HSSREFCLKVALID,
  input  logic                           HSSPDWNPLL,
  input  logic [NUM_LANES*DATAWIDTH-1:0] TXD,
  input  logic [NUM_LANES-1:0]           LOOPBACK_EN,
  input  logic [NUM_LANES-1:0]           TXQUIET,
  input  logic [NUM_LANES-1:0]           RXBITSLIP,
  output logic                           HSSPLLLOCK,
  output logic                           HSSPRTREADY,
  output logic [NUM_LANES*DATAWIDTH-1:0] RXD,
  output logic [NUM_LANES-1:0]           RXDVALID
);

  hss_state_e       state_q;
  hss_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             lock_q;
  logic             rdy_q;
  logic             ok;
  logic             ready;
  logic             flush;

  assign ok = link_ok(HSSREFCLKVALID, HSSPDWNPLL);

  // Sequencer next state; loss of clock/PLL beats counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RST: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
      ST_WAIT_LOCK: begin
        if (ok) begin
          if (cnt_q == CNT_W'(LOCK_DLY - 1)) begin
            state_d = ST_WAIT_RDY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT_RDY: begin
        if (!ok) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(RDY_DLY - 1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        if (!ok) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state, counter and registered status outputs.
  always_ff @(posedge HSSREFCLKAC or posedge HSSRESET) begin
    if (HSSRESET) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock_q  <= (state_d == ST_WAIT_RDY) ||
                 (state_d == ST_READY);
      rdy_q   <= (state_d == ST_READY);
    end
  end

  assign HSSPLLLOCK  = lock_q;
  assign HSSPRTREADY = rdy_q;

  assign ready = (state_q == ST_READY);
  assign flush = (state_d != ST_READY);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fake_hss_lane #(
      .DW     (DATAWIDTH),
      .LB_LAT (LB_LAT)
    ) u_lane (
      .clk_i   (HSSREFCLKAC),
      .rst_i   (HSSRESET),
      .ready_i (ready),
      .flush_i (flush),
      .en_i    (LOOPBACK_EN[i]),
      .quiet_i (TXQUIET[i]),
      .slip_i  (RXBITSLIP[i]),
      .txd_i   (TXD[i*DATAWIDTH +: DATAWIDTH]),
      .rxd_o   (RXD[i*DATAWIDTH +: DATAWIDTH]),
      .rxv_o   (RXDVALID[i])
    );
  end

endmodule

// File: doc/fake_hss_nlane.md
FAKE_HSS_NLANE -- requirements
Module: fake_hss_nlane

Interface
REQ-001 Parameter NUM_LANES, default 4, number of serial lanes modelled.
REQ-002 Parameter DATAWIDTH, default 40, parallel data width per lane.
REQ-003 Parameter LOCK_DLY, default 64, HSSREFCLKAC cycles from WAIT_LOCK entry to HSSPLLLOCK assertion; legal range 1..1023.
REQ-004 Parameter RDY_DLY, default 16, cycles from HSSPLLLOCK to HSSPRTREADY; legal range 1..1023.
REQ-005 Parameter LB_LAT, default 2, TX-to-RX loopback latency in cycles; legal range 1..8.
REQ-006 HSSREFCLKAC  in  1  sole clock; all state on rising edge.
REQ-007 HSSRESET  in  1  reset, asynchronous, active-high.
REQ-008 HSSREFCLKVALID  in  1  reference clock valid; low forces relock.
REQ-009 HSSPDWNPLL  in  1  PLL power-down; high forces relock.
REQ-010 TXD  in  NUM_LANES*DATAWIDTH  lane transmit data, lane i at bits [i*DATAWIDTH +: DATAWIDTH].
REQ-011 LOOPBACK_EN  in  NUM_LANES  per-lane loopback enable.
REQ-012 TXQUIET  in  NUM_LANES  per-lane transmit squelch.
REQ-013 RXBITSLIP  in  NUM_LANES  per-lane single-cycle slip request.
REQ-014 HSSPLLLOCK  out  1  PLL locked.
REQ-015 HSSPRTREADY  out  1  port ready.
REQ-016 RXD  out  NUM_LANES*DATAWIDTH  lane receive data, same packing as TXD.
REQ-017 RXDVALID  out  NUM_LANES  per-lane receive data valid.

Function
REQ-018 Sequencer states: RST, WAIT_LOCK, WAIT_RDY, READY; RST left unconditionally on first edge after reset release, to WAIT_LOCK.
REQ-019 WAIT_LOCK: 10-bit counter cleared on entry, increments each cycle while HSSREFCLKVALID=1 and HSSPDWNPLL=0, holds otherwise; reaching LOCK_DLY-1 -> WAIT_RDY.
REQ-020 WAIT_RDY: counter cleared on entry, increments each cycle; reaching RDY_DLY-1 -> READY.
REQ-021 HSSPLLLOCK registered, high exactly in WAIT_RDY and READY; HSSPRTREADY registered, high exactly in READY.
REQ-022 From WAIT_RDY or READY, HSSREFCLKVALID=0 or HSSPDWNPLL=1 -> WAIT_LOCK next cycle; both outputs low that cycle; has priority over counter expiry.
REQ-023 Per lane, stage-0 valid = READY & LOOPBACK_EN[i] & ~TXQUIET[i]; stage-0 data = TXD lane when valid, else zero.
REQ-024 Data/valid pair travels LB_LAT register stages; TXD in cycle n appears on RXD/RXDVALID in cycle n+LB_LAT.
REQ-025 Per-lane slip offset, range 0..DATAWIDTH-1; RXBITSLIP=1 in READY increments offset next cycle; DATAWIDTH-1 wraps to 0; RXBITSLIP ignored outside READY.
REQ-026 RXD lane bit j = delayed data bit (j+offset) mod DATAWIDTH; offset applied combinationally at output, so a slip takes effect on the cycle after the request regardless of LB_LAT.
REQ-027 Leaving READY clears all pipeline stages and all offsets in the same edge that drops HSSPRTREADY; RXD=0 and RXDVALID=0 from that cycle until fresh data propagates.
REQ-028 Toggling LOOPBACK_EN or TXQUIET mid-stream affects only newly entering stages; in-flight words complete.
REQ-029 Lanes are independent; simultaneous slip on several lanes all take effect.

Reset
REQ-030 HSSRESET=1 asynchronously forces state RST, counters 0, HSSPLLLOCK=0, HSSPRTREADY=0, RXD=0, RXDVALID=0, all offsets 0.
REQ-031 Reset asserted mid-operation discards in-flight loopback data; full LOCK_DLY+RDY_DLY sequence repeats after release.

Structure
REQ-032 Shared package fake_hss_pkg holds state enum, counter width constant (10), and parameter defaults.
REQ-033 Sub-module fake_hss_lane implements one lane's pipeline, valid gating and slip rotator; top generates NUM_LANES instances plus the sequencer.

Verification
REQ-034 Defaults, release reset at cycle 0, VALID=1 -> HSSPLLLOCK rises cycle 65, HSSPRTREADY rises cycle 81 (+/-0 cycles vs model).
REQ-035 READY, lane 2 LOOPBACK_EN=1, TXD lane2=40'h00_0000_0001 cycle n -> RXD lane2 same value, RXDVALID[2]=1 at cycle n+2; other lanes valid 0.
REQ-036 Lane 0 looping constant 40'h1, pulse RXBITSLIP[0] once -> RXD lane0 = 40'h80_0000_0000 from next cycle; 40 pulses total -> back to 40'h1.
REQ-037 In READY drop HSSREFCLKVALID one cycle -> both outputs low next cycle, RXDVALID all 0, offsets 0; relock after 64+16 cycles.
REQ-038 TXQUIET[1]=1 with lane 1 looping -> RXD lane1=0, RXDVALID[1]=0 after LB_LAT cycles; NUM_LANES=8, DATAWIDTH=64, LB_LAT=5 rerun of REQ-035 latency check.
